// File: rtl/rsa_pkg.sv
// Shared definitions for the lab2 RSA datapath: operand width, counter width
// and the controller state encoding used by the Montgomery stage and its neighbours.
package rsa_pkg;

  localparam int RSA_WIDTH = 256;
  localparam int RSA_CNT_W = $clog2(RSA_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FINAL = 2'd2
  } rsa_state_e;

endpackage

// File: rtl/rsa_mont_step.sv
// One radix-2 Montgomery iteration: conditionally add B, then add N if the sum
// is odd, then halve. Purely combinational.
module rsa_mont_step
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic [WIDTH:0]   m_i,
  input  logic             a_bit_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] n_i,
  output logic [WIDTH:0]   m_next_o
);

  logic [WIDTH+1:0] sumB;
  logic [WIDTH+1:0] sumN;

  // m < 2N keeps m + B + N below 4N, so WIDTH+2 bits never overflow.
  always_comb begin
    sumB     = {1'b0, m_i} + (a_bit_i ? {2'b00, b_i} : '0);
    sumN     = sumB + (sumB[0] ? {2'b00, n_i} : '0);
    m_next_o = (WIDTH+1)'(sumN >> 1);
  end

endmodule

// File: rtl/rsa_montgomery.sv
// Montgomery modular multiplier: o_result = A*B*2^-WIDTH mod N using WIDTH
// radix-2 iterations followed by a single conditional subtraction.
module rsa_montgomery
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH,
  parameter int ITER  = WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_n,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result,
  output logic             o_finish
);

  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

  rsa_state_e       state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH:0]   m_q, m_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             finish_q, finish_d;

  logic [WIDTH:0]   mStep;
  logic [WIDTH:0]   nExt;

  rsa_mont_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .m_i     (m_q),
    .a_bit_i (a_q[cnt_q]),
    .b_i     (b_q),
    .n_i     (n_q),
    .m_next_o(mStep)
  );

  assign nExt = {1'b0, n_q};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      finish_q <= finish_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    finish_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          n_d     = i_n;
          a_d     = i_a;
          b_d     = i_b;
          m_d     = '0;
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end

      S_CALC: begin
        m_d = mStep;
        if (cnt_q == LAST_CNT) begin
          state_d = S_FINAL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_FINAL: begin
        // m < 2N here, so one subtraction brings it into [0, N).
        result_d = (m_q >= nExt) ? WIDTH'(m_q - nExt) : WIDTH'(m_q);
        finish_d = 1'b1;
        state_d  = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_result = result_q;
  assign o_finish = finish_q;

endmodule

// File: tb/tb_rsa_montgomery.sv
// Scoreboard bench for rsa_montgomery: stimulus pushes expected results and
// start edges, a monitor pops them whenever o_finish pulses.
module tb_rsa_montgomery;

  localparam int W = 256;
  localparam int LATENCY = 257;

  typedef struct {
    logic [W-1:0] result;
    int           startEdge;
  } exp_t;

  logic         clk;
  logic         rstN;
  logic         start;
  logic [W-1:0] n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] result;
  logic         finish;

  int   edgeCount;
  logic lastRstN;
  int   tests;
  int   failures;
  exp_t expQ[$];
  logic [W-1:0] heldResult;

  rsa_montgomery dut (
    .i_clk   (clk),
    .i_rst_n (rstN),
    .i_start (start),
    .i_n     (n),
    .i_a     (a),
    .i_b     (b),
    .o_result(result),
    .o_finish(finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    edgeCount = 0;
    lastRstN  = 1'b0;
  end

  always @(posedge clk) begin
    edgeCount <= edgeCount + 1;
    lastRstN  <= rstN;
  end

  // Reference: reduce A*B mod N, then multiply by 2^-1 mod N 256 times
  // (modular halving: add N when odd, then shift).
  function automatic logic [W-1:0] refMont(input logic [W-1:0] nv, input logic [W-1:0] av,
                                           input logic [W-1:0] bv);
    logic [2*W-1:0] x;
    x = ({{W{1'b0}}, av} * {{W{1'b0}}, bv}) % {{W{1'b0}}, nv};
    for (int k = 0; k < W; k++) begin
      if (x[0]) x = x + {{W{1'b0}}, nv};
      x = x >> 1;
    end
    return x[W-1:0];
  endfunction

  function automatic logic [W-1:0] randWide();
    logic [W-1:0] v;
    for (int k = 0; k < W / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    tests++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the start edge.
  task automatic applyStimulus(input logic [W-1:0] nv, input logic [W-1:0] av,
                               input logic [W-1:0] bv, input logic [W-1:0] expv);
    exp_t e;
    n     = nv;
    a     = av;
    b     = bv;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start       = 1'b0;
    e.result    = expv;
    e.startEdge = edgeCount;
    expQ.push_back(e);
  endtask

  task automatic waitIdle(input int bound);
    for (int k = 0; k < bound && expQ.size() != 0; k++) @(negedge clk);
    tests++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL timeout: %0d results outstanding, expected 0", expQ.size());
      expQ.delete();
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic monitorLoop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!lastRstN) begin
        checkOutput("resetResult", result, '0);
        checkOutput("resetFinish", {{(W-1){1'b0}}, finish}, '0);
        heldResult = '0;
      end else if (finish) begin
        if (expQ.size() == 0) begin
          tests++;
          failures++;
          $display("[TB] FAIL unexpectedFinish: got finish with result %h, expected no finish", result);
        end else begin
          e = expQ.pop_front();
          checkOutput("result", result, e.result);
          checkOutput("latency", W'(edgeCount - e.startEdge), W'(LATENCY));
          heldResult = e.result;
        end
      end else begin
        checkOutput("heldResult", result, heldResult);
      end
    end
  endtask

  initial begin
    logic [W-1:0] nv, av, bv, big, half, quarter;
    int s;
    tests      = 0;
    failures   = 0;
    heldResult = '0;
    rstN  = 1'b0;
    start = 1'b0;
    n     = '0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    fork
      monitorLoop();
    join_none
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);

    // Basic: 2^-256 mod 7 = 4
    applyStimulus(W'(7), W'(1), W'(1), W'(4));
    waitIdle(400);
    // Identity with R mod N
    applyStimulus(W'(7), W'(2), W'(5), W'(5));
    waitIdle(400);
    // Full-width carries
    big     = '1;
    half    = '0;
    half[W-1] = 1'b1;
    quarter = '0;
    quarter[W-2] = 1'b1;
    applyStimulus(big, half, half, quarter);
    waitIdle(400);

    // A = 0, then back-to-back start accepted in the finish cycle
    nv = randWide() | W'(1);
    applyStimulus(nv, '0, nv - W'(1), '0);
    repeat (LATENCY) @(negedge clk);
    applyStimulus(W'(5), W'(1), W'(1), W'(1));
    waitIdle(400);

    // Start pulse mid-operation with different operands is ignored
    applyStimulus(W'(7), W'(1), W'(1), W'(4));
    repeat (99) @(negedge clk);
    n     = W'(5);
    a     = W'(3);
    b     = W'(2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitIdle(400);
    repeat (20) @(negedge clk);

    // Reset at cycle 50 aborts the operation
    applyStimulus(W'(7), W'(1), W'(1), W'(4));
    repeat (49) @(negedge clk);
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    expQ.delete();
    repeat (300) @(negedge clk);
    applyStimulus(W'(7), W'(3), W'(6), refMont(W'(7), W'(3), W'(6)));
    waitIdle(400);

    // Randomized operands, mix of small and full-width moduli
    for (int t = 0; t < 10; t++) begin
      if (t % 3 == 0) nv = W'($urandom_range(3, 5000)) | W'(1);
      else            nv = randWide() | W'(1);
      av = randWide() % nv;
      bv = randWide() % nv;
      s  = t;
      applyStimulus(nv, av, bv, refMont(nv, av, bv));
      if (s % 2 == 1) begin
        repeat (LATENCY) @(negedge clk);
      end else begin
        waitIdle(400);
      end
    end
    waitIdle(400);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
